// File: rtl/broadcast_unpool.sv
// broadcast_unpool: replays one vector as WIDTH*HEIGHT Q-format pixels; define BROADCAST_SAT_EN to saturate instead of wrap
module broadcast_unpool #(
  parameter int WIDTH = 4,
  parameter int HEIGHT = 4,
  parameter int VALUE_BITS = 32,
  parameter int CHANNELS = 4,
  parameter int VALUE_Q_FORMAT_N = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [CHANNELS*VALUE_BITS-1:0] i_data,
  input  logic                           i_valid,
  output logic                           i_ready,
  output logic [CHANNELS*VALUE_BITS-1:0] o_data,
  output logic                           o_valid,
  input  logic                           o_ready,
  output logic                           o_last
);
  localparam int PIXELS = WIDTH * HEIGHT;
  localparam int CW = $clog2(PIXELS) > 1 ? $clog2(PIXELS) : 1;
  localparam logic [CW-1:0] LAST = CW'(PIXELS - 1);
  localparam int N = VALUE_Q_FORMAT_N;
  typedef enum logic {IDLE, EMIT} state_t;
  state_t state_q;
  logic [CW-1:0] cnt_q;
  logic [CHANNELS*VALUE_BITS-1:0] held_q;
  logic i_ready_q, o_valid_q, o_last_q;
  assign i_ready = i_ready_q;
  assign o_valid = o_valid_q;
  assign o_last = o_last_q;
  // Capture a vector in IDLE, then count pixel handshakes until the last one; handshake flags are registered with the state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      held_q <= '0;
      i_ready_q <= 1'b1;
      o_valid_q <= 1'b0;
      o_last_q <= 1'b0;
    end else if (state_q == IDLE) begin
      if (i_valid) begin
        state_q <= EMIT;
        held_q <= i_data;
        cnt_q <= '0;
        i_ready_q <= 1'b0;
        o_valid_q <= 1'b1;
        o_last_q <= (PIXELS == 1);
      end
    end else if (o_ready) begin
      if (o_last_q) begin
        state_q <= IDLE;
        cnt_q <= '0;
        i_ready_q <= 1'b1;
        o_valid_q <= 1'b0;
        o_last_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
        o_last_q <= (cnt_q + 1'b1 == LAST);
      end
    end
  end
  for (genvar c = 0; c < CHANNELS; c++) begin : g_conv
    logic [VALUE_BITS-1:0] x;
    assign x = held_q[c*VALUE_BITS +: VALUE_BITS];
`ifdef BROADCAST_SAT_EN
    logic ovf;
    // Value fits in the integer part only if its top N+1 bits are pure sign extension
    always_comb begin
      ovf = x[VALUE_BITS-1 -: N+1] != {(N+1){x[VALUE_BITS-1]}};
      o_data[c*VALUE_BITS +: VALUE_BITS] = ovf ? {x[VALUE_BITS-1], {(VALUE_BITS-1){~x[VALUE_BITS-1]}}} : x << N;
    end
`else
    // Plain shift into the fractional position, wrapping on overflow
    always_comb o_data[c*VALUE_BITS +: VALUE_BITS] = x << N;
`endif
  end
endmodule

// File: tb/tb_broadcast_unpool.sv
// tb_broadcast_unpool: scoreboard bench for broadcast_unpool (2x2 and 1x1 images)
module tb_broadcast_unpool;
  localparam int VB = 32, CH = 4, DW = VB * CH;
  typedef struct {logic [DW-1:0] d; logic l;} px_t;
  logic clk = 0, reset = 1;
  logic [DW-1:0] i_data = '0, o_data, i_data1 = '0, o_data1;
  logic i_valid = 0, i_ready, o_valid, o_ready, o_last;
  logic i_valid1 = 0, i_ready1, o_valid1, o_ready1 = 1, o_last1;
  int n_checks = 0, n_fail = 0, cyc = 0, hs = 0, bp_i = 0;
  logic bp = 0, stalled = 0, prev_l;
  logic [DW-1:0] prev_d;
  px_t q[$], q1[$], e, e1;

  broadcast_unpool #(.WIDTH(2), .HEIGHT(2)) u_dut (
    .clk(clk), .reset(reset), .i_data(i_data), .i_valid(i_valid), .i_ready(i_ready),
    .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready), .o_last(o_last));

  broadcast_unpool #(.WIDTH(1), .HEIGHT(1)) u_dut1 (
    .clk(clk), .reset(reset), .i_data(i_data1), .i_valid(i_valid1), .i_ready(i_ready1),
    .o_data(o_data1), .o_valid(o_valid1), .o_ready(o_ready1), .o_last(o_last1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    o_ready = bp ? (bp_i % 4 == 0 || bp_i % 4 == 3) : 1'b1;
    bp_i++;
  end

  task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) stalled = 0;
    else begin
      if (stalled) begin
        check("stall_data", o_data, prev_d);
        check("stall_last", o_last, prev_l);
      end
      if (o_valid) check("i_ready_in_emit", i_ready, 0);
      stalled = o_valid && !o_ready;
      prev_d = o_data;
      prev_l = o_last;
      if (o_valid && o_ready) begin
        if (q.size() == 0) check("unexpected_pixel", 1, 0);
        else begin
          e = q.pop_front();
          check("pixel_data", o_data, e.d);
          check("pixel_last", o_last, e.l);
        end
        hs++;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && o_valid1 && o_ready1) begin
      if (q1.size() == 0) check("unexpected_pixel_1x1", 1, 0);
      else begin
        e1 = q1.pop_front();
        check("pixel_data_1x1", o_data1, e1.d);
        check("pixel_last_1x1", o_last1, e1.l);
      end
    end
  end

  task automatic send(logic [DW-1:0] d, logic [DW-1:0] exp);
    int t = 0;
    i_data = d;
    i_valid = 1;
    do begin @(negedge clk); t++; end while (!i_ready && t < 50);
    if (!i_ready) check("accept_timeout", 0, 1);
    for (int k = 0; k < 4; k++) q.push_back('{exp, k == 3});
    @(posedge clk); #1;
    i_valid = 0;
  endtask

  task automatic wait_done();
    int t = 0;
    while ((q.size() != 0 || !i_ready) && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) check("drain_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int t, h0;
    int acc[3];
    logic [DW-1:0] v1[3], x1[3];
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check("reset_o_valid", o_valid, 0);
    check("reset_o_last", o_last, 0);
    check("reset_o_data", o_data, 0);
    check("reset_i_ready", i_ready, 1);
    check("reset_i_ready_1x1", i_ready1, 1);
    check("reset_o_valid_1x1", o_valid1, 0);
    @(posedge clk); #1;

    send({32'd0, 32'd3, 32'hFFFFFFFE, 32'd1}, {32'h0, 32'h00030000, 32'hFFFE0000, 32'h00010000});
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c <= 4) begin
        check("timing_o_valid", o_valid, 1);
        check("timing_o_last", o_last, c == 4);
      end else begin
        check("timing_i_ready_after_last", i_ready, 1);
        check("timing_o_valid_after_last", o_valid, 0);
      end
    end
    wait_done();

    bp = 1;
    bp_i = 0;
    send({32'd0, 32'd3, 32'hFFFFFFFE, 32'd1}, {32'h0, 32'h00030000, 32'hFFFE0000, 32'h00010000});
    wait_done();
    bp = 0;

`ifdef BROADCAST_SAT_EN
    send({96'd0, 32'd40000}, {96'd0, 32'h7FFFFFFF});
    wait_done();
    send({96'd0, 32'hFFFF63C0}, {96'd0, 32'h80000000});
`else
    send({96'd0, 32'd40000}, {96'd0, 32'h9C400000});
    wait_done();
    send({96'd0, 32'hFFFF63C0}, {96'd0, 32'h63C00000});
`endif
    wait_done();

    h0 = hs;
    send({32'd2, 32'd0, 32'd0, 32'd0}, {32'h00020000, 96'd0});
    t = 0;
    while (hs < h0 + 2 && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) check("reset_wait_timeout", 0, 1);
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1;
    q.delete();
    q1.delete();
    reset = 0;
    @(negedge clk);
    check("midreset_o_valid", o_valid, 0);
    check("midreset_o_last", o_last, 0);
    check("midreset_i_ready", i_ready, 1);
    @(posedge clk); #1;
    send({32'd0, 32'd0, 32'd4, 32'd0}, {32'h0, 32'h0, 32'h00040000, 32'h0});
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check("post_reset_last", o_last, c == 4);
    end
    wait_done();

    send({32'd9, 32'd8, 32'd7, 32'd6}, {32'h00090000, 32'h00080000, 32'h00070000, 32'h00060000});
    i_valid = 1;
    i_data = {32'd1, 32'd1, 32'd1, 32'd1};
    @(posedge clk); #1;
    i_data = {32'd5, 32'd5, 32'd5, 32'd5};
    @(posedge clk); #1;
    i_valid = 0;
    wait_done();
    repeat (5) @(posedge clk);
    #1;

    v1[0] = {32'd7, 32'd0, 32'hFFFFFFFF, 32'd5};
    x1[0] = {32'h00070000, 32'h0, 32'hFFFF0000, 32'h00050000};
    v1[1] = {96'd0, 32'h00007FFF};
    x1[1] = {96'd0, 32'h7FFF0000};
    v1[2] = {96'd0, 32'hFFFF8000};
    x1[2] = {96'd0, 32'h80000000};
    i_valid1 = 1;
    for (int k = 0; k < 3; k++) begin
      i_data1 = v1[k];
      q1.push_back('{x1[k], 1'b1});
      t = 0;
      do begin @(negedge clk); t++; end while (!i_ready1 && t < 20);
      if (!i_ready1) check("accept_timeout_1x1", 0, 1);
      acc[k] = cyc;
      @(posedge clk); #1;
    end
    i_valid1 = 0;
    check("accept_spacing_a", acc[1] - acc[0], 2);
    check("accept_spacing_b", acc[2] - acc[1], 2);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("queue_empty", q.size(), 0);
    check("queue_empty_1x1", q1.size(), 0);
    check("final_o_valid", o_valid, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/broadcast_unpool.md
# broadcast_unpool

Streaming broadcast block: accepts one per-channel integer vector and emits WIDTH×HEIGHT pixels, each carrying that vector converted back to signed fixed-point. It is the expanding counterpart of the image-reduction sum stage and regenerates a full image from a pooled vector. It sits between a vector producer (reduction or FC stage) and any pixel-stream consumer, using the same valid/ready/last pixel protocol.

## Interface
- WIDTH, 4, output image width in pixels (≥1)
- HEIGHT, 4, output image height in pixels (≥1)
- VALUE_BITS, 32, bits per channel value
- CHANNELS, 4, channels per pixel
- VALUE_Q_FORMAT_N, 16, fractional bits of the output format (< VALUE_BITS)

- clk  input  1  clock; all logic on its rising edge
- reset  input  1  reset, synchronous, active-high
- i_data  input  signed VALUE_BITS × CHANNELS  integer-valued vector, one per image
- i_valid  input  1  i_data valid
- i_ready  output  1  block can accept a vector
- o_data  output  signed VALUE_BITS × CHANNELS  output pixel, Q(VALUE_BITS−N−1).N
- o_valid  output  1  o_data valid
- o_ready  input  1  consumer accepts pixel
- o_last  output  1  pixel is the last of its image

## Operation
- Two states: IDLE, EMIT. Pixel counter cnt: width max(1, $clog2(WIDTH*HEIGHT)). Holding register held[CHANNELS].
- IDLE: i_ready=1, o_valid=0, o_last=0. On i_valid && i_ready: held ← i_data, cnt ← 0, go to EMIT.
- EMIT: i_ready=0, o_valid=1, o_data[c] = conv(held[c]) for every pixel. o_last = (cnt == WIDTH*HEIGHT−1).
- On o_valid && o_ready with o_last=0: cnt ← cnt+1. With o_last=1: go to IDLE, cnt ← 0.
- o_valid is never withdrawn without a handshake. o_data and o_last are held stable while o_valid && !o_ready.
- conv(x) = x << VALUE_Q_FORMAT_N, truncated to VALUE_BITS (wraps), unless BROADCAST_SAT_EN is defined.
- WIDTH*HEIGHT = 1: a single pixel with o_last=1, then return to IDLE.
- Reset: state IDLE, cnt 0, held all zeros. Outputs after reset: o_valid=0, o_last=0, o_data=conv(0)=0, i_ready=1. Inputs are ignored while reset is high.
- Reset mid-EMIT aborts the image immediately. The remaining pixels and o_last are never emitted.

## Timing
- i_ready and o_valid are registered-state decodes, not combinational paths from i_valid or o_ready.
- Accept at edge k: first pixel is valid in cycle k+1 (1-cycle latency).
- Last-pixel handshake at edge m: i_ready=1 in cycle m+1. A new vector cannot be accepted in the same cycle as the last handshake.
- Throughput with o_ready held at 1: WIDTH*HEIGHT+1 cycles per vector (one IDLE bubble).
- o_ready stalls add exactly one cycle per stalled cycle and do not change the output sequence.
- i_valid while in EMIT: ignored. The producer must hold i_data until it sees i_ready.

## Configuration
- Macro BROADCAST_SAT_EN:
  - Defined: conv saturates. If x > 2^(VALUE_BITS−N−1)−1, output is 2^(VALUE_BITS−1)−1. If x < −2^(VALUE_BITS−N−1), output is −2^(VALUE_BITS−1). Otherwise output is x<<N.
  - Undefined: plain left shift with wrap-around. No comparison logic is generated.
  - Latency is identical in both builds.

## Test plan
- Defaults at WIDTH=HEIGHT=2, o_ready=1. Vector {1,−2,3,0} accepted at edge 0 -> pixels in cycles 1..4, each {0x00010000, 0xFFFE0000, 0x00030000, 0}. o_last=1 only in cycle 4. i_ready=1 in cycle 5.
- Backpressure: same setup, o_ready toggled 1,0,0,1,… -> exactly 4 pixels, data and o_last stable during stalls. i_ready stays 0 until after the last handshake.
- Overflow: i_data[0]=40000, −40000 in turn. Without BROADCAST_SAT_EN -> 0x9C400000 and 0x63C00000. With it defined -> 0x7FFFFFFF and 0x80000000.
- Reset mid-image: reset asserted after the 2nd pixel handshake -> next cycle o_valid=0, o_last=0, i_ready=1. A new vector then produces a full 4-pixel image starting at cnt 0.
- WIDTH=HEIGHT=1: back-to-back vectors with i_valid held high -> one pixel per vector, each with o_last=1. Vectors are accepted every 2 cycles.
- i_valid asserted with changing i_data during EMIT -> output values unchanged, no extra pixels emitted.
